pito_dmem_port_arbiter: RTL and testbench

//  Shares one port of the dual-port data SRAM between NUM_REQ requesters (e.g. host loader, MVU, debug).

---
 rtl/pito_dmem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_pito_dmem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pito_dmem_port_arbiter.sv
// rtl/pito_dmem_port_arbiter.sv - round-robin arbiter with bounded burst lock for one data SRAM port
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i/lock_i/we_i   per-requester request, burst lock, write enable
//   addr_i/wdata_i/be_i packed per-requester address, write data, byte enables (requester 0 in LSBs)
//   gnt_o               one-hot grant, same cycle as the accepted request
//   rvalid_o            one-hot read-data valid, one cycle after a read grant
//   rdata_o             shared read data, qualified by rvalid_o
//   mem_*               single SRAM port (latency 1 on reads)
module pito_dmem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_REQ    = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            lock_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_REQ*BE_WIDTH-1:0]   be_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [BE_WIDTH-1:0]           mem_be_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // With a one-deep burst limit the very first locked grant already exhausts the budget.
    localparam bit ONE_DEEP = (MAX_BURST == 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [PTR_W-1:0]   sel;
    logic               found;
    logic               locked_hit;
    logic               others_pending;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rvalid_q;

    // (p + k) mod NUM_REQ; NUM_REQ need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        return PTR_W'((int'(p) + k) % NUM_REQ);
    endfunction

    // Grant selection: the lock owner keeps the port while it requests; otherwise
    // (including the cycle the owner drops its request) search from rr_ptr upward.
    always_comb begin
        sel        = '0;
        found      = 1'b0;
        locked_hit = (state_q == LOCKED) && req_i[owner_q];
        if (locked_hit) begin
            sel   = owner_q;
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req_i[wrap_add(rr_ptr_q, k)]) begin
                    sel   = wrap_add(rr_ptr_q, k);
                    found = 1'b1;
                end
            end
        end
        gnt = '0;
        gnt[sel] = found;
    end

    // Grants are suppressed while reset is held so the SRAM never sees a request.
    assign gnt_o     = gnt & {NUM_REQ{rst_n}};
    assign mem_req_o = |gnt_o;

    // With no grant, sel stays 0 and the data path follows requester 0.
    assign mem_we_o    = we_i[sel];
    assign mem_addr_o  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_wdata_o = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign mem_be_o    = be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];

    assign rdata_o  = mem_rdata_i;
    assign rvalid_o = rvalid_q;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        burst_cnt_d    = burst_cnt_q;
        others_pending = |(req_i & ~(NUM_REQ'(1) << sel));
        cnt_inc        = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);

        // Owner stopped requesting: this cycle is arbitrated as IDLE.
        if (state_q == LOCKED && !locked_hit) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
        end

        if (found) begin
            if (locked_hit) begin
                burst_cnt_d = cnt_inc;
                // Release on unlock, or on an exhausted budget when someone else waits;
                // with nobody waiting the lock continues and the count saturates.
                if (!lock_i[sel] || (cnt_inc == CNT_W'(MAX_BURST) && others_pending)) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    rr_ptr_d    = wrap_add(sel, 1);
                end
            end else if (lock_i[sel] && !(ONE_DEEP && others_pending)) begin
                state_d     = LOCKED;
                owner_d     = sel;
                burst_cnt_d = CNT_W'(1);
            end else begin
                rr_ptr_d = wrap_add(sel, 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= gnt_o & ~we_i;
        end
    end

endmodule

// File: tb/tb_pito_dmem_port_arbiter.sv
// tb/tb_pito_dmem_port_arbiter.sv - self-checking bench for pito_dmem_port_arbiter
module tb_pito_dmem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int BW = 4;
    localparam int NR = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NR-1:0]  req_v = '0;
    logic [NR-1:0]  lock_v = '0;
    logic [NR-1:0]  we_v = '0;
    logic [AW-1:0]  addr_v [NR];
    logic [DW-1:0]  wdata_v [NR];
    logic [BW-1:0]  be_v [NR];

    logic [NR-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]    rdata_o, mem_wdata_o, mem_rdata_i;
    logic             mem_req_o, mem_we_o;
    logic [AW-1:0]    mem_addr_o;
    logic [BW-1:0]    mem_be_o;

    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pito_dmem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW), .NUM_REQ(NR), .MAX_BURST(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(req_v),
        .lock_i(lock_v),
        .we_i(we_v),
        .addr_i({addr_v[1], addr_v[0]}),
        .wdata_i({wdata_v[1], wdata_v[0]}),
        .be_i({be_v[1], be_v[0]}),
        .gnt_o(gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // SRAM model, read latency 1
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end else begin
                mem_rdata_i <= mem[mem_addr_o];
            end
        end
    end

    // Read-return scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid_o != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected cyc=%0d actual rvalid=%b expected none", cyc, rvalid_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.due != cyc || rvalid_o !== (2'b01 << e.idx) || rdata_o !== e.data) begin
                        errors++;
                        $display("FAIL rvalid_data cyc=%0d actual rvalid=%b rdata=%h expected rvalid=%b rdata=%h due=%0d",
                                 cyc, rvalid_o, rdata_o, 2'b01 << e.idx, e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                checks++;
                errors++;
                $display("FAIL rvalid_missing cyc=%0d actual rvalid=%b expected req%0d", cyc, rvalid_o, sb[0].idx);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_port(input int i, input logic r, input logic l, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        req_v[i]   = r;
        lock_v[i]  = l;
        we_v[i]    = w;
        addr_v[i]  = a;
        wdata_v[i] = d;
        be_v[i]    = b;
    endtask

    // One clock: check the grant at the negedge, record expected read data / write effect, advance.
    task automatic cycle(input logic [NR-1:0] exp_gnt);
        int g;
        @(negedge clk);
        checks++;
        if (gnt_o !== exp_gnt || mem_req_o !== (|exp_gnt)) begin
            errors++;
            $display("FAIL grant cyc=%0d actual gnt=%b req=%b expected gnt=%b req=%b",
                     cyc, gnt_o, mem_req_o, exp_gnt, |exp_gnt);
        end
        if (exp_gnt != '0) begin
            g = exp_gnt[1] ? 1 : 0;
            checks++;
            if (mem_addr_o !== addr_v[g] || mem_we_o !== we_v[g]) begin
                errors++;
                $display("FAIL mux cyc=%0d actual addr=%h we=%b expected addr=%h we=%b",
                         cyc, mem_addr_o, mem_we_o, addr_v[g], we_v[g]);
            end
            if (we_v[g]) begin
                for (int b = 0; b < BW; b++)
                    if (be_v[g][b]) ref_mem[addr_v[g]][b*8 +: 8] = wdata_v[g][b*8 +: 8];
            end else begin
                sb.push_back('{idx: g, data: ref_mem[addr_v[g]], due: cyc + 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, '0, 4'hF);
        set_port(1, 1'b1, 1'b0, 1'b0, 12'h020, '0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt_o !== 2'b00 || mem_req_o !== 1'b0 || rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs actual gnt=%b req=%b rvalid=%b expected 00 0 00", gnt_o, mem_req_o, rvalid_o);
        end
        req_v = '0;
        rst_n = 1'b1;
        cycle(2'b00);
    endtask

    task automatic test_single_read();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, '0, 4'hF);
        cycle(2'b01);
        req_v = '0;
        checks++;
        if (rvalid_o !== 2'b01 || rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_read actual rvalid=%b rdata=%h expected 01 deadbeef", rvalid_o, rdata_o);
        end
        cycle(2'b00);
    endtask

    task automatic test_alternate();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h020, '0, 4'hF);
        set_port(1, 1'b1, 1'b0, 1'b0, 12'h030, '0, 4'hF);
        repeat (3) begin
            cycle(2'b10);
            cycle(2'b01);
        end
        req_v = '0;
        cycle(2'b00);
    endtask

    task automatic test_burst_lock();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h020, '0, 4'hF);
        set_port(1, 1'b1, 1'b1, 1'b0, 12'h031, '0, 4'hF);
        repeat (8) cycle(2'b10);
        cycle(2'b01);
        req_v[0] = 1'b0;
        repeat (12) cycle(2'b10);
        req_v[0] = 1'b1;
        cycle(2'b10);
        cycle(2'b01);
    endtask

    task automatic test_drop_mid_lock();
        req_v[0] = 1'b0;
        cycle(2'b10);
        cycle(2'b10);
        req_v[1] = 1'b0;
        req_v[0] = 1'b1;
        cycle(2'b01);
        req_v = '0;
        lock_v = '0;
        cycle(2'b00);
    endtask

    task automatic test_write_then_read();
        set_port(0, 1'b1, 1'b0, 1'b1, 12'h040, 32'h12345678, 4'b0011);
        cycle(2'b01);
        set_port(0, 1'b0, 1'b0, 1'b0, 12'h040, '0, 4'hF);
        set_port(1, 1'b1, 1'b0, 1'b0, 12'h040, '0, 4'hF);
        cycle(2'b10);
        req_v = '0;
        checks++;
        if (rvalid_o !== 2'b10 || rdata_o !== 32'h00005678) begin
            errors++;
            $display("FAIL write_read actual rvalid=%b rdata=%h expected 10 00005678", rvalid_o, rdata_o);
        end
        cycle(2'b00);
    endtask

    task automatic test_reset_mid_op();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, '0, 4'hF);
        cycle(2'b01);
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (rvalid_o !== 2'b00 || gnt_o !== 2'b00 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid actual rvalid=%b gnt=%b req=%b expected 00 00 0", rvalid_o, gnt_o, mem_req_o);
        end
        req_v = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(2'b00);
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h020, '0, 4'hF);
        set_port(1, 1'b1, 1'b0, 1'b0, 12'h030, '0, 4'hF);
        cycle(2'b01);
        cycle(2'b10);
        req_v = '0;
        cycle(2'b00);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
        mem[12'h020] = 32'hA5A50020; ref_mem[12'h020] = 32'hA5A50020;
        mem[12'h030] = 32'h5A5A0030; ref_mem[12'h030] = 32'h5A5A0030;
        mem[12'h031] = 32'hC0DE0031; ref_mem[12'h031] = 32'hC0DE0031;
        mem_rdata_i = '0;
        for (int i = 0; i < NR; i++) set_port(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        test_reset();
        test_single_read();
        test_alternate();
        test_burst_lock();
        test_drop_mid_lock();
        test_write_then_read();
        test_reset_mid_op();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
